spi_target_regif: RTL and testbench
===================================

Name: spi_target_regif

Overview:
- Parametrised SPI target (peripheral) that turns MSB-first {address, data} frames into single-cycle register-write strobes on the sys_clock domain.
- Also supports register readback on POCI during the data phase of the same frame, and a fixed chip-ID readback.
- Supports all four CPOL/CPHA modes; all SPI inputs are synchronised internally.
- Sits between the chip pads and the register file / controller.

Parameters:
- ADDR_W, 4: address field width, in bits.
- DATA_W, 12: data field width, in bits. Frame length FRAME_W = ADDR_W + DATA_W.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = the reverse.
- SYNC_STAGES, 2: synchroniser depth for SCLK, SS and PICO (2 or more).
- ID_ADDR, 'hA: read-only address that returns CHIP_ID.
- CHIP_ID, 'h78: chip ID value, zero-extended to DATA_W.

Ports:
- sys_clock  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- SCLK  in  1  SPI clock (asynchronous to sys_clock).
- SS  in  1  target select, active-low.
- PICO  in  1  serial data in.
- POCI  out  1  serial data out (always driven, no tristate).
- rd_addr  out  ADDR_W  read address, held valid from rd_en until the end of the frame.
- rd_en  out  1  one-cycle read request.
- rd_data  in  DATA_W  read data, sampled exactly 1 cycle after rd_en.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- wr_en  out  1  one-cycle write strobe.
- frame_abort  out  1  one-cycle pulse when a frame ends early.

Behaviour:
- Reset (rst_n low, asynchronous) clears: POCI, rd_en, wr_en, frame_abort, rd_addr, wr_addr, wr_data, all counters and shift registers; state = IDLE; synchroniser flops set to the idle values SS=1, SCLK=CPOL.
- Input path: SCLK, SS and PICO each pass through SYNC_STAGES flops.
  - Sample and shift edges are decoded from the synchronised SCLK, using CPOL/CPHA, as one-cycle pulses.
  - Required clock ratio: f(sys_clock) ≥ 8 × f(SCLK).
- States:
  - IDLE: wait for synchronised SS low, then go to ADDR with bit count 0.
  - ADDR: shift in one bit per sample pulse. After bit ADDR_W-1:
    - latch rd_addr;
    - pulse rd_en on the next cycle;
    - capture rd_data (or CHIP_ID when address == ID_ADDR) on the cycle after that;
    - go to DATA.
  - DATA: shift in DATA_W bits. After bit FRAME_W-1 go to DONE.
  - DONE: on the next cycle, pulse wr_en and drive wr_addr/wr_data from the frame; these hold until the next strobe. Further SCLK edges are ignored until SS rises; SS high then returns to IDLE.
- POCI:
  - 0 in IDLE, in ADDR, and after the last data bit.
  - In DATA, the readback word goes out MSB-first. Its MSB is driven on the first shift pulse after the last address sample, then one bit per subsequent shift pulse.
- Writes to ID_ADDR are suppressed: no wr_en; state goes to DONE as normal.
- SS rising in ADDR or DATA (frame incomplete): abort.
  - No wr_en; frame_abort pulses 1 cycle; POCI = 0; return to IDLE.
  - A rd_en already issued is not retracted.
- SS rising in the same cycle as the final sample pulse: the frame completes (the sample wins); wr_en fires and there is no abort.
- SS falling in IDLE while synchronised SCLK is not at CPOL: no sample or shift pulse is produced until SCLK first returns to idle (prevents a spurious first edge).
- rst_n asserted mid-frame: immediate return to reset values; no strobes.
- Bit counter width = $clog2(FRAME_W+1); no wrap within a frame.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, ADDR, DATA, DONE);
  - defaults for ADDR_W, DATA_W, ID_ADDR, CHIP_ID;
  - typedef for mode {cpol, cpha}.
- One sub-module, spi_sync_edge: SYNC_STAGES synchronisers plus sample/shift pulse decode, parametrised by CPOL/CPHA.
- FSM, shifters and POCI logic stay in spi_target_regif.

Test Plan:
- Mode 0, frame 0x3ABC → exactly one wr_en, with wr_addr=3 and wr_data=0xABC; frame_abort=0.
- Mode 0, frame 0xA000 → POCI carries 0x078 MSB-first over the 12 data bits; no wr_en.
- Mode 0, frame 0x5000 with rd_data=0x5A5 → rd_en pulses once, rd_addr=5; POCI carries 0x5A5; wr_en fires with data 0x000.
- SS raised after 10 bits of 0x3ABC → frame_abort pulses once, no wr_en. A following 0x1FFF frame → wr_addr=1, wr_data=0xFFF.
- rst_n pulsed low after 6 bits → all outputs 0 immediately. Next frame 0x2123 → wr_addr=2, wr_data=0x123.
- Repeat the first three scenarios with CPOL=1/CPHA=1 and with ADDR_W=6/DATA_W=16 → identical results.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI target register interface.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 12;
    localparam int DEF_ID_ADDR = 'hA;
    localparam int DEF_CHIP_ID = 'h78;

    function automatic spi_mode_t make_mode(input bit cpol, input bit cpha);
        spi_mode_t m;
        m.cpol = cpol;
        m.cpha = cpha;
        return m;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises SCLK/SS/PICO into the system clock domain and decodes the
// SCLK edges into one-cycle sample and shift pulses for the selected mode.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter spi_mode_t MODE        = '0,
    parameter int        SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_ss,
    input  logic i_pico,
    output logic o_ss,
    output logic o_pico,
    output logic o_sample,
    output logic o_shift
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_pico_sync;
    logic                   r_sclk_prev;
    logic                   r_armed;
    logic                   w_sclk;
    logic                   w_edge;
    logic                   w_leading;
    logic                   w_trailing;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign o_ss   = r_ss_sync[SYNC_STAGES-1];
    assign o_pico = r_pico_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{MODE.cpol}};
            r_ss_sync   <= '1;
            r_pico_sync <= '0;
            r_sclk_prev <= MODE.cpol;
            r_armed     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
            r_pico_sync <= {r_pico_sync[SYNC_STAGES-2:0], i_pico};
            r_sclk_prev <= w_sclk;
            // Edges only count once SCLK has been seen at its idle level, so a
            // select that lands mid-pulse cannot produce a spurious first edge.
            if (o_ss) begin
                r_armed <= (w_sclk == MODE.cpol);
            end else if (w_sclk == MODE.cpol) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_edge     = (w_sclk != r_sclk_prev) && r_armed;
    assign w_leading  = w_edge && (r_sclk_prev == MODE.cpol);
    assign w_trailing = w_edge && (w_sclk == MODE.cpol);
    assign o_sample   = MODE.cpha ? w_trailing : w_leading;
    assign o_shift    = MODE.cpha ? w_leading : w_trailing;

endmodule

// File: rtl/spi_target_regif.sv
// SPI target turning MSB-first {address, data} frames into register write
// strobes, with same-frame readback on POCI and a fixed chip-ID address.
module spi_target_regif
    import spi_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter int ID_ADDR     = DEF_ID_ADDR,
    parameter int CHIP_ID     = DEF_CHIP_ID
) (
    input  logic              i_sys_clock,
    input  logic              i_rst_n,
    input  logic              i_sclk,
    input  logic              i_ss,
    input  logic              i_pico,
    output logic              o_poci,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_en,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_en,
    output logic              o_frame_abort,
    output state_t            o_state
);

    localparam int                FRAME_W   = ADDR_W + DATA_W;
    localparam int                CNT_W     = $clog2(FRAME_W + 1);
    localparam logic [ADDR_W-1:0] ID_A      = ADDR_W'(ID_ADDR);
    localparam logic [DATA_W-1:0] ID_VAL    = DATA_W'(CHIP_ID);
    localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam spi_mode_t         MODE      = make_mode(CPOL, CPHA);

    logic               w_ss;
    logic               w_pico;
    logic               w_sample;
    logic               w_shift;
    state_t             r_state;
    state_t             w_state_next;
    logic               w_addr_done;
    logic               w_frame_done;
    logic               w_abort;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-2:0] r_shift;
    logic [FRAME_W-1:0] w_shift_next;
    logic [DATA_W-1:0]  r_tx;
    logic               r_cap_pend;
    logic               r_poci;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_wr_en;
    logic               r_frame_abort;

    spi_sync_edge #(
        .MODE        (MODE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk    (i_sys_clock),
        .i_rst_n  (i_rst_n),
        .i_sclk   (i_sclk),
        .i_ss     (i_ss),
        .i_pico   (i_pico),
        .o_ss     (w_ss),
        .o_pico   (w_pico),
        .o_sample (w_sample),
        .o_shift  (w_shift)
    );

    assign w_shift_next = {r_shift, w_pico};

    always_ff @(posedge i_sys_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The final sample outranks a simultaneous SS rise so a frame that just
    // made it still commits.
    always_comb begin
        w_state_next = r_state;
        w_addr_done  = 1'b0;
        w_frame_done = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_ss) w_state_next = ADDR;
            end
            ADDR: begin
                if (w_ss) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (w_sample && (r_cnt == LAST_ADDR)) begin
                    w_addr_done  = 1'b1;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_sample && (r_cnt == LAST_BIT)) begin
                    w_frame_done = 1'b1;
                    w_state_next = DONE;
                end else if (w_ss) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            DONE: begin
                if (w_ss) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt         <= '0;
            r_shift       <= '0;
            r_tx          <= '0;
            r_cap_pend    <= 1'b0;
            r_poci        <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_en       <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_rd_en       <= w_addr_done;
            r_cap_pend    <= r_rd_en;
            r_wr_en       <= 1'b0;
            r_frame_abort <= w_abort;

            if (r_state == IDLE) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_sample && ((r_state == ADDR) || (r_state == DATA))) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shift <= w_shift_next[FRAME_W-2:0];
            end

            if (w_addr_done) begin
                r_rd_addr <= w_shift_next[ADDR_W-1:0];
            end

            // Read data arrives one cycle after the rd_en pulse.
            if (r_cap_pend) begin
                r_tx <= (r_rd_addr == ID_A) ? ID_VAL : i_rd_data;
            end

            if (w_frame_done && (w_shift_next[FRAME_W-1:DATA_W] != ID_A)) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_shift_next[FRAME_W-1:DATA_W];
                r_wr_data <= w_shift_next[DATA_W-1:0];
            end

            if ((r_state == DATA) && w_shift && !w_abort) begin
                r_poci <= r_tx[DATA_W-1];
                r_tx   <= r_tx << 1;
            end else if ((r_state != DATA) || w_abort || w_frame_done) begin
                r_poci <= 1'b0;
            end
        end
    end

    assign o_poci        = r_poci;
    assign o_rd_addr     = r_rd_addr;
    assign o_rd_en       = r_rd_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_wr_en       = r_wr_en;
    assign o_frame_abort = r_frame_abort;
    assign o_state       = r_state;

endmodule

// File: tb/tb_spi_target_regif.sv
// Bench for spi_target_regif: two instances (mode 0 with 4/12 fields, mode 3
// with 6/16 fields) driven by an SPI controller model and a register-file model.
module tb_spi_target_regif;
    import spi_pkg::*;

    localparam int HALF = 80;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sclk_a[2];
    logic ss_a[2];
    logic pico_a[2];
    logic cpol_a[2] = '{1'b0, 1'b1};
    logic cpha_a[2] = '{1'b0, 1'b1};
    int   aw_a[2]   = '{4, 6};
    int   dw_a[2]   = '{12, 16};

    logic        poci0, rd_en0, wr_en0, abort0;
    logic [3:0]  rd_addr0, wr_addr0;
    logic [11:0] rd_data0, wr_data0;
    state_t      state0;
    logic        poci1, rd_en1, wr_en1, abort1;
    logic [5:0]  rd_addr1, wr_addr1;
    logic [15:0] rd_data1, wr_data1;
    state_t      state1;

    logic        poci_v[2], rd_en_v[2], wr_en_v[2], abort_v[2];
    logic [31:0] rd_addr_v[2], wr_addr_v[2], wr_data_v[2], state_v[2];

    logic [15:0] mem_a[2][64];
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_ab_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    spi_target_regif #(.ADDR_W(4), .DATA_W(12), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .i_sys_clock(clk), .i_rst_n(rst_n), .i_sclk(sclk_a[0]), .i_ss(ss_a[0]),
        .i_pico(pico_a[0]), .o_poci(poci0), .o_rd_addr(rd_addr0), .o_rd_en(rd_en0),
        .i_rd_data(rd_data0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0),
        .o_wr_en(wr_en0), .o_frame_abort(abort0), .o_state(state0)
    );

    spi_target_regif #(.ADDR_W(6), .DATA_W(16), .CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
        .i_sys_clock(clk), .i_rst_n(rst_n), .i_sclk(sclk_a[1]), .i_ss(ss_a[1]),
        .i_pico(pico_a[1]), .o_poci(poci1), .o_rd_addr(rd_addr1), .o_rd_en(rd_en1),
        .i_rd_data(rd_data1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1),
        .o_wr_en(wr_en1), .o_frame_abort(abort1), .o_state(state1)
    );

    assign poci_v[0] = poci0;  assign poci_v[1] = poci1;
    assign rd_en_v[0] = rd_en0; assign rd_en_v[1] = rd_en1;
    assign wr_en_v[0] = wr_en0; assign wr_en_v[1] = wr_en1;
    assign abort_v[0] = abort0; assign abort_v[1] = abort1;
    assign rd_addr_v[0] = 32'(rd_addr0); assign rd_addr_v[1] = 32'(rd_addr1);
    assign wr_addr_v[0] = 32'(wr_addr0); assign wr_addr_v[1] = 32'(wr_addr1);
    assign wr_data_v[0] = 32'(wr_data0); assign wr_data_v[1] = 32'(wr_data1);
    assign state_v[0] = 32'(state0); assign state_v[1] = 32'(state1);

    // Register-file model: data valid the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        rd_data0 <= rd_en0 ? mem_a[0][{2'b00, rd_addr0}][11:0] : 12'($urandom);
        rd_data1 <= rd_en1 ? mem_a[1][rd_addr1] : 16'($urandom);
    end

    function automatic logic [31:0] pack(input int d, input logic [31:0] a, input logic [31:0] v);
        return (32'(d) << 24) | (a << 16) | v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Monitor: every strobe the DUTs present is matched against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (wr_en_v[d]) begin
                    if (exp_wr_q.size() == 0) unexpected("wr_strobe", pack(d, wr_addr_v[d], wr_data_v[d]));
                    else check("wr_strobe", pack(d, wr_addr_v[d], wr_data_v[d]), exp_wr_q.pop_front());
                end
                if (rd_en_v[d]) begin
                    if (exp_rd_q.size() == 0) unexpected("rd_strobe", pack(d, rd_addr_v[d], 0));
                    else check("rd_strobe", pack(d, rd_addr_v[d], 0), exp_rd_q.pop_front());
                end
                if (abort_v[d]) begin
                    if (exp_ab_q.size() == 0) unexpected("abort_pulse", pack(d, 0, 1));
                    else check("abort_pulse", pack(d, 0, 1), exp_ab_q.pop_front());
                end
            end
        end
    end

    // end_mode: 0 normal, 1 SS rises with the final sample edge, 3 leave SS low.
    task automatic xfer(input int d, input logic [31:0] frame, input int nbits,
                        input int end_mode, output logic [31:0] rx);
        int fw;
        fw = aw_a[d] + dw_a[d];
        rx = '0;
        ss_a[d] = 1'b0;
        #(2 * HALF);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha_a[d]) begin
                pico_a[d] = frame[fw-1-i];
                #HALF;
                rx = {rx[30:0], poci_v[d]};
                sclk_a[d] = ~cpol_a[d];
                if (end_mode == 1 && i == nbits - 1) ss_a[d] = 1'b1;
                #HALF;
                sclk_a[d] = cpol_a[d];
            end else begin
                sclk_a[d] = ~cpol_a[d];
                pico_a[d] = frame[fw-1-i];
                #HALF;
                rx = {rx[30:0], poci_v[d]};
                sclk_a[d] = cpol_a[d];
                if (end_mode == 1 && i == nbits - 1) ss_a[d] = 1'b1;
                #HALF;
            end
        end
        #HALF;
        if (end_mode != 3) begin
            ss_a[d] = 1'b1;
            pico_a[d] = 1'b0;
            #(3 * HALF);
        end
    endtask

    task automatic run_frame(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input int nbits, input int end_mode);
        int fw;
        logic [31:0] rx, rb;
        fw = aw_a[d] + dw_a[d];
        rb = (addr == 32'hA) ? 32'h78 : 32'(mem_a[d][addr[5:0]]);
        if (nbits >= aw_a[d]) exp_rd_q.push_back(pack(d, addr, 0));
        if (nbits < fw) exp_ab_q.push_back(pack(d, 0, 1));
        else if (addr != 32'hA) exp_wr_q.push_back(pack(d, addr, data));
        xfer(d, (addr << dw_a[d]) | data, nbits, end_mode, rx);
        if (nbits == fw) begin
            check("poci_readback", rx, rb);
            if (addr != 32'hA) mem_a[d][addr[5:0]] = data[15:0];
        end
    endtask

    task automatic glitch_select(input int d);
        sclk_a[d] = ~cpol_a[d];
        #HALF;
        ss_a[d] = 1'b0;
        #HALF;
        sclk_a[d] = cpol_a[d];
        #HALF;
    endtask

    task automatic check_reset_outputs(input int d);
        check("reset_poci", 32'(poci_v[d]), 0);
        check("reset_rd_en", 32'(rd_en_v[d]), 0);
        check("reset_wr_en", 32'(wr_en_v[d]), 0);
        check("reset_abort", 32'(abort_v[d]), 0);
        check("reset_rd_addr", rd_addr_v[d], 0);
        check("reset_wr_addr", wr_addr_v[d], 0);
        check("reset_wr_data", wr_data_v[d], 0);
        check("reset_state", state_v[d], 32'(IDLE));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, sel, fw;
        logic [31:0] a, v;
        for (int k = 0; k < 2; k++) begin
            sclk_a[k] = cpol_a[k];
            ss_a[k]   = 1'b1;
            pico_a[k] = 1'b0;
            for (int m = 0; m < 64; m++) mem_a[k][m] = 16'($urandom_range(0, (1 << dw_a[k]) - 1));
        end
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            fw = aw_a[k] + dw_a[k];
            run_frame(k, 3, 'hABC, fw, 0);
            run_frame(k, 'hA, 0, fw, 0);
            mem_a[k][5] = 16'h5A5;
            run_frame(k, 5, 0, fw, 0);
            run_frame(k, 3, 'hABC, 10, 0);
            run_frame(k, 1, 'hFFF, fw, 0);
            run_frame(k, 7, 32'($urandom_range(0, (1 << dw_a[k]) - 1)), fw, 1);
            glitch_select(k);
            run_frame(k, 2, 32'($urandom_range(0, (1 << dw_a[k]) - 1)), fw, 0);
        end

        exp_rd_q.push_back(pack(0, 3, 0));
        begin
            logic [31:0] rx;
            xfer(0, 32'h3ABC, 6, 3, rx);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        ss_a[0] = 1'b1;
        pico_a[0] = 1'b0;
        #(2 * HALF);
        @(negedge clk);
        rst_n = 1'b1;
        #(2 * HALF);
        run_frame(0, 2, 'h123, 16, 0);

        repeat (30) begin
            d  = $urandom_range(0, 1);
            fw = aw_a[d] + dw_a[d];
            sel = $urandom_range(0, 9);
            a = (sel == 0) ? 32'hA : 32'($urandom_range(0, (1 << aw_a[d]) - 1));
            v = 32'($urandom_range(0, (1 << dw_a[d]) - 1));
            if (sel >= 8) run_frame(d, a, v, $urandom_range(1, fw - 1), 0);
            else if (sel >= 6) run_frame(d, a, v, fw, 1);
            else run_frame(d, a, v, fw, 0);
        end

        repeat (20) @(negedge clk);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 0);
        check("abort_queue_drained", 32'(exp_ab_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
